// File: rtl/pll_lock_supervisor_if.sv
// Purpose : bundles the PLL-facing and system-facing signals of the lock supervisor.
// Latency : none, wires only.
// Backpressure: none; every signal is a level.
//
// Signals:
//   locked_in  - PLL locked output, asynchronous to clk (into the supervisor)
//   pll_areset - active-high PLL reset request
//   sys_rst_n  - active-low synchronous reset for downstream logic
//   ready      - high only while the PLL is locked and released
//   fault      - sticky failure flag
//   retry_cnt  - lock timeouts since the last successful lock
//   loss_count - lock-loss events seen while running, saturating at 255
interface pll_lock_supervisor_if;
  logic       locked_in;
  logic       pll_areset;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_count;

  // Supervisor side
  modport master (
    input  locked_in,
    output pll_areset, sys_rst_n, ready, fault, retry_cnt, loss_count
  );

  // PLL / system side
  modport slave (
    output locked_in,
    input  pll_areset, sys_rst_n, ready, fault, retry_cnt, loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Purpose : sequences the board PLL reset and releases sys_rst_n only after lock has been stable.
// Latency : locked_in change to state reaction is 3 clk; first lock_s to sys_rst_n=1 is SETTLE_CYCLES+1.
// Backpressure: none; pure level-driven supervisor, every output registered.
//
// Ports:
//   clk   - 50 MHz board clock (same net as PLL inclk0)
//   rst_n - synchronous active-low reset
//   bus   - pll_lock_supervisor_if.master (locked_in in; pll_areset, sys_rst_n,
//           ready, fault, retry_cnt, loss_count out)
// Optional feature: define PLL_LOSS_COUNTER_EN to build the 8-bit saturating
// lock-loss counter; without it loss_count is tied to zero.
module pll_lock_supervisor #(
  parameter int AREST_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pll_lock_supervisor_if.master  bus
);

  localparam int MAX_AT  = (AREST_CYCLES > TIMEOUT_CYCLES) ? AREST_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_SR  = (SETTLE_CYCLES > MAX_RETRIES) ? SETTLE_CYCLES : MAX_RETRIES;
  localparam int MAX_ALL = (MAX_AT > MAX_SR) ? MAX_AT : MAX_SR;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  // A state ends on the edge that closes its Nth cycle, so compare against N-1.
  localparam logic [CW-1:0] AREST_LAST   = CW'(AREST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    MAX_R        = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    retry, retry_nxt;
  logic          sync1, lock_s;
  logic          areset_q, sys_rst_n_q, ready_q, fault_q;

  // Two-flop synchronizer; nothing else looks at locked_in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.locked_in;
      lock_s <= sync1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    unique case (state)
      PLL_RST: begin
        if (cnt == AREST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_nxt = SETTLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_nxt = retry + 4'd1;
          state_nxt = (retry_nxt == MAX_R) ? FAULT : PLL_RST;
        end
      end
      SETTLE: begin
        // Any drop restarts the wait; the counter only sees consecutive lock cycles.
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = RUN;
          retry_nxt = 4'd0;
        end
      end
      RUN: begin
        if (!lock_s) state_nxt = PLL_RST;
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = PLL_RST;
      end
    endcase

    // Counter clears on every state entry and idles in states that never time out.
    if (state_nxt != state || state == RUN || state == FAULT) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // State register plus outputs decoded from the next state, so they are registered
  // and change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= PLL_RST;
      cnt         <= '0;
      retry       <= 4'd0;
      areset_q    <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry       <= retry_nxt;
      areset_q    <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
      sys_rst_n_q <= (state_nxt == RUN);
      ready_q     <= (state_nxt == RUN);
      fault_q     <= (state_nxt == FAULT);
    end
  end

  assign bus.pll_areset = areset_q;
  assign bus.sys_rst_n  = sys_rst_n_q;
  assign bus.ready      = ready_q;
  assign bus.fault      = fault_q;
  assign bus.retry_cnt  = retry;

`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  // A loss is exactly the RUN -> PLL_RST transition.
  assign loss_evt = (state == RUN) && !lock_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.loss_count = loss_q;
`else
  assign bus.loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose : directed self-checking bench for pll_lock_supervisor (AREST=4, TIMEOUT=32, SETTLE=8, RETRIES=2).
// Latency : inputs driven and outputs sampled 1 time unit after each rising clk edge.
// Backpressure: n/a; every wait on the DUT is bounded.
module tb_pll_lock_supervisor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #10 clk = ~clk;

  pll_lock_supervisor_if ifc ();

  pll_lock_supervisor #(
    .AREST_CYCLES  (4),
    .TIMEOUT_CYCLES(32),
    .SETTLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_loss(input int n);
`ifdef PLL_LOSS_COUNTER_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  // Ticks until sys_rst_n reaches lvl; returns the tick count (== bound if it never did).
  task automatic wait_sys(input logic lvl, input int bound, output int n);
    n = 0;
    while (ifc.sys_rst_n !== lvl && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset(input string tag, input int exp_lc);
    chk({tag, "_areset"}, ifc.pll_areset, 1);
    chk({tag, "_sys"},    ifc.sys_rst_n,  0);
    chk({tag, "_ready"},  ifc.ready,      0);
    chk({tag, "_fault"},  ifc.fault,      0);
    chk({tag, "_retry"},  ifc.retry_cnt,  0);
    chk({tag, "_loss"},   ifc.loss_count, exp_lc);
  endtask

  initial begin
    int n;
    ifc.locked_in = 1'b0;

    // Power-on reset
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset("por", 0);

    // Normal lock: areset high through release tick 3, locked_in at tick 10, release 11 ticks later
    rst_n = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("norm_areset", ifc.pll_areset, (t < 4) ? 1 : 0);
      chk("norm_sys", ifc.sys_rst_n, 0);
    end
    ifc.locked_in = 1'b1;
    wait_sys(1'b1, 100, n);
    chk("norm_release", n, 11);
    chk("norm_ready", ifc.ready, 1);
    chk("norm_retry", ifc.retry_cnt, 0);
    chk("norm_fault", ifc.fault, 0);
    chk("norm_areset_run", ifc.pll_areset, 0);

    // Lock loss in RUN: 1-tick drop, sys_rst_n falls on tick 3, 4-tick areset, release at tick 16
    ifc.locked_in = 1'b0;
    tick();
    chk("loss_sys_k1", ifc.sys_rst_n, 1);
    ifc.locked_in = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      tick();
      chk("loss_sys", ifc.sys_rst_n, (k < 3 || k >= 16) ? 1 : 0);
      chk("loss_areset", ifc.pll_areset, (k >= 3 && k <= 6) ? 1 : 0);
      if (k == 3) begin
        chk("loss_count", ifc.loss_count, exp_loss(1));
        chk("loss_ready", ifc.ready, 0);
      end
    end

    // Reset from RUN, then settle abort: 5 lock, 3 drop, then steady lock
    rst_n = 1'b0;
    ifc.locked_in = 1'b0;
    tick();
    chk_reset("rst_run", 0);
    rst_n = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    ifc.locked_in = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("abort_sys_hi", ifc.sys_rst_n, 0);
    end
    ifc.locked_in = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk("abort_sys_lo", ifc.sys_rst_n, 0);
    end
    ifc.locked_in = 1'b1;
    wait_sys(1'b1, 100, n);
    chk("abort_release", n, 11);
    chk("abort_retry", ifc.retry_cnt, 0);

    // Reset while in SETTLE, then relock with locked_in already high
    rst_n = 1'b0;
    ifc.locked_in = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    ifc.locked_in = 1'b1;
    for (int t = 1; t <= 5; t++) tick();
    rst_n = 1'b0;
    tick();
    chk_reset("rst_settle", 0);
    rst_n = 1'b1;
    wait_sys(1'b1, 100, n);
    chk("settle_relock", n, 13);

    // Timeout to fault: pulses at ticks 0-3 and 36-39, fault from tick 72, lock at 81 ignored
    rst_n = 1'b0;
    ifc.locked_in = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 100; t++) begin
      if (t == 81) ifc.locked_in = 1'b1;
      tick();
      chk("to_areset", ifc.pll_areset, (t < 4 || (t >= 36 && t < 40) || t >= 72) ? 1 : 0);
      chk("to_fault", ifc.fault, (t >= 72) ? 1 : 0);
      chk("to_retry", ifc.retry_cnt, (t < 36) ? 0 : ((t < 72) ? 1 : 2));
      chk("to_sys", ifc.sys_rst_n, 0);
    end

    // Reset while in FAULT
    rst_n = 1'b0;
    tick();
    chk_reset("rst_fault", 0);
    rst_n = 1'b1;

    // Saturation: 260 lock losses from RUN
    wait_sys(1'b1, 100, n);
    chk("sat_first_release", n, 13);
    for (int i = 1; i <= 260; i++) begin
      ifc.locked_in = 1'b0;
      tick();
      ifc.locked_in = 1'b1;
      wait_sys(1'b0, 10, n);
      chk("sat_drop", n, 2);
      chk("sat_loss", ifc.loss_count, exp_loss(i));
      wait_sys(1'b1, 100, n);
      chk("sat_relock", n, 13);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
